// File: rtl/hilo_ctrl_if.sv
// hilo_ctrl_if
// Bundles the EX-stage request, read-port and result signals of the Hi/Lo
// sequencer. The master side is the pipeline (EX stage / test driver), the
// slave side is hilo_ctrl itself.

interface hilo_ctrl_if;

    // Operation request channel
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        op_ready;
    logic        busy;

    // MFHI / MFLO read port and hazard signalling
    logic        rd_req;
    logic        rd_sel;
    logic [31:0] rd_data;
    logic        stall;

    // Status and register observation
    logic        div_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    modport master (
        output op_valid,
        output op_code,
        output src_a,
        output src_b,
        output rd_req,
        output rd_sel,
        input  op_ready,
        input  busy,
        input  rd_data,
        input  stall,
        input  div_zero,
        input  hi_out,
        input  lo_out
    );

    modport slave (
        input  op_valid,
        input  op_code,
        input  src_a,
        input  src_b,
        input  rd_req,
        input  rd_sel,
        output op_ready,
        output busy,
        output rd_data,
        output stall,
        output div_zero,
        output hi_out,
        output lo_out
    );

endinterface

// File: rtl/hilo_ctrl.sv
// hilo_ctrl
// Hi/Lo special-register sequencer for the MIPS-Lite pipeline. Executes
// MULTU/DIVU with a 32-iteration shift-add multiplier / restoring divider,
// handles MTHI/MTLO writes and serves MFHI/MFLO reads, raising stall while
// a read collides with an operation in flight.
//
// Optional feature macro: HILO_SIGNED_EN
//   defined   -> MULT/DIV (codes 100/101) supported via magnitude conversion
//                at accept and a FIX state that restores the signs.
//   undefined -> unsigned only; codes 100/101 are accepted and dropped.
//
// Reset is asynchronous and active-low on the port named 'reset'.

module hilo_ctrl (
    input  logic        clk,
    input  logic        reset,
    hilo_ctrl_if.slave  bus
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_MUL  = 3'd1;
    localparam logic [2:0] ST_DIV  = 3'd2;
`ifdef HILO_SIGNED_EN
    localparam logic [2:0] ST_FIX  = 3'd3;
`endif
    localparam logic [2:0] ST_DONE = 3'd4;

    // ------------------------------------------------------------------
    // Operation codes
    // ------------------------------------------------------------------
    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_DIVU  = 3'b001;
    localparam logic [2:0] OP_MTHI  = 3'b010;
    localparam logic [2:0] OP_MTLO  = 3'b011;
`ifdef HILO_SIGNED_EN
    localparam logic [2:0] OP_MULT  = 3'b100;
    localparam logic [2:0] OP_DIV   = 3'b101;
`endif

    localparam logic [5:0] LAST_ITER = 6'd31;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]  state;
    logic [5:0]  count;
    // acc holds {upper, multiplier} during MUL and {remainder, quotient}
    // during DIV; DONE always commits acc[63:32] to Hi and acc[31:0] to Lo.
    logic [63:0] acc;
    // Multiplicand for MUL, divisor for DIV (magnitudes for signed ops).
    logic [31:0] opnd;
    logic        dz_flag;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;

`ifdef HILO_SIGNED_EN
    logic        sign_a;
    logic        sign_b;
    logic        signed_op;
    logic        is_div;
`endif

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic        accept;
    logic        req_mul;
    logic        req_div;
    logic        req_mthi;
    logic        req_mtlo;
    logic        req_signed;
    logic        req_dz;
    logic [31:0] mag_a;
    logic [31:0] mag_b;

    assign accept = bus.op_valid && (state == ST_IDLE);

    // Classify the incoming opcode; anything unrecognised decodes to nothing
    // and is therefore silently dropped once accepted.
    always_comb begin
        req_mul    = 1'b0;
        req_div    = 1'b0;
        req_mthi   = 1'b0;
        req_mtlo   = 1'b0;
        req_signed = 1'b0;
        case (bus.op_code)
            OP_MULTU: req_mul  = 1'b1;
            OP_DIVU:  req_div  = 1'b1;
            OP_MTHI:  req_mthi = 1'b1;
            OP_MTLO:  req_mtlo = 1'b1;
`ifdef HILO_SIGNED_EN
            OP_MULT: begin
                req_mul    = 1'b1;
                req_signed = 1'b1;
            end
            OP_DIV: begin
                req_div    = 1'b1;
                req_signed = 1'b1;
            end
`endif
            default: begin
                req_mul  = 1'b0;
                req_div  = 1'b0;
            end
        endcase
    end

    assign req_dz = req_div && (bus.src_b == 32'd0);

    // Signed operands enter the datapath as magnitudes; the signs are
    // reapplied in FIX once the unsigned iteration has finished.
    always_comb begin
        mag_a = bus.src_a;
        mag_b = bus.src_b;
        if (req_signed && bus.src_a[31]) begin
            mag_a = ~bus.src_a + 32'd1;
        end
        if (req_signed && bus.src_b[31]) begin
            mag_b = ~bus.src_b + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] rem_sh;
    logic [31:0] quo_sh;
    logic [32:0] diff;
    logic [63:0] div_next;

    // One shift-add multiply step: conditionally add the multiplicand into
    // the upper half (keeping the carry), then shift the 65-bit value right.
    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        mul_next = {mul_sum, acc[31:1]};
    end

    // One restoring-divide step. The remainder is always below the divisor,
    // so the shifted remainder minus divisor fits in 33 bits with bit 32
    // acting as the borrow/sign flag.
    always_comb begin
        rem_sh = {acc[63:32], acc[31]};
        quo_sh = {acc[30:0], 1'b0};
        diff   = rem_sh - {1'b0, opnd};
        if (diff[32]) begin
            div_next = {rem_sh[31:0], quo_sh};
        end else begin
            div_next = {diff[31:0], quo_sh | 32'd1};
        end
    end

`ifdef HILO_SIGNED_EN
    logic [63:0] fix_next;
    logic [31:0] rem_neg;
    logic [31:0] quo_neg;

    // Sign restoration: products take sign_a ^ sign_b, quotients the same,
    // remainders follow the dividend sign.
    always_comb begin
        rem_neg  = ~acc[63:32] + 32'd1;
        quo_neg  = ~acc[31:0] + 32'd1;
        fix_next = acc;
        if (is_div) begin
            fix_next[63:32] = sign_a ? rem_neg : acc[63:32];
            fix_next[31:0]  = (sign_a ^ sign_b) ? quo_neg : acc[31:0];
        end else if (sign_a ^ sign_b) begin
            fix_next = ~acc + 64'd1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------

    // Main control FSM: loads operands on accept, iterates 32 times, then
    // hands the result to DONE for the commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            count     <= 6'd0;
            acc       <= 64'd0;
            opnd      <= 32'd0;
            dz_flag   <= 1'b0;
`ifdef HILO_SIGNED_EN
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            signed_op <= 1'b0;
            is_div    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
`ifdef HILO_SIGNED_EN
                        sign_a    <= req_signed && bus.src_a[31];
                        sign_b    <= req_signed && bus.src_b[31];
                        signed_op <= req_signed && !req_dz;
                        is_div    <= req_div;
`endif
                        count <= 6'd0;
                        if (req_mul) begin
                            acc   <= {32'd0, mag_b};
                            opnd  <= mag_a;
                            state <= ST_MUL;
                        end else if (req_dz) begin
                            acc     <= {bus.src_a, 32'hFFFF_FFFF};
                            dz_flag <= 1'b1;
                            state   <= ST_DONE;
                        end else if (req_div) begin
                            acc   <= {32'd0, mag_a};
                            opnd  <= mag_b;
                            state <= ST_DIV;
                        end
                    end
                end
                ST_MUL: begin
                    acc   <= mul_next;
                    count <= count + 6'd1;
                    if (count == LAST_ITER) begin
`ifdef HILO_SIGNED_EN
                        state <= signed_op ? ST_FIX : ST_DONE;
`else
                        state <= ST_DONE;
`endif
                    end
                end
                ST_DIV: begin
                    acc   <= div_next;
                    count <= count + 6'd1;
                    if (count == LAST_ITER) begin
`ifdef HILO_SIGNED_EN
                        state <= signed_op ? ST_FIX : ST_DONE;
`else
                        state <= ST_DONE;
`endif
                    end
                end
`ifdef HILO_SIGNED_EN
                ST_FIX: begin
                    acc   <= fix_next;
                    state <= ST_DONE;
                end
`endif
                ST_DONE: begin
                    dz_flag <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Architectural Hi/Lo: MT writes land at the accepting edge, iterative
    // results land at the DONE edge. The two can never coincide because MT
    // is only accepted in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_reg <= 32'd0;
            lo_reg <= 32'd0;
        end else if (state == ST_DONE) begin
            hi_reg <= acc[63:32];
            lo_reg <= acc[31:0];
        end else begin
            if (accept && req_mthi) begin
                hi_reg <= bus.src_a;
            end
            if (accept && req_mtlo) begin
                lo_reg <= bus.src_a;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.op_ready = (state == ST_IDLE);
    assign bus.busy     = (state != ST_IDLE);
    assign bus.rd_data  = bus.rd_sel ? hi_reg : lo_reg;
    assign bus.stall    = bus.rd_req && (state != ST_IDLE);
    assign bus.div_zero = (state == ST_DONE) && dz_flag;
    assign bus.hi_out   = hi_reg;
    assign bus.lo_out   = lo_reg;

endmodule

// File: doc/hilo_ctrl.md
# hilo_ctrl

Sequencer for the Hi/Lo special registers of the pipelined MIPS-Lite CPU. Accepts MULTU/DIVU/MTHI/MTLO from the EX stage, runs a 32-iteration shift-add multiplier or restoring divider, and commits the 64-bit result to Hi/Lo. It serves MFHI/MFLO reads and stalls the pipeline when a read arrives while an operation is in flight.

## Interface
- No parameters; data width fixed at 32, result 64.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- op_valid  in  1  operation request from EX
- op_code  in  3  000 MULTU, 001 DIVU, 010 MTHI, 011 MTLO, 100 MULT, 101 DIV (signed codes need HILO_SIGNED_EN), others illegal
- src_a  in  32  rs operand (multiplicand / dividend / MT data)
- src_b  in  32  rt operand (multiplier / divisor)
- op_ready  out  1  high only in IDLE; request accepted when op_valid && op_ready at clk edge
- busy  out  1  state != IDLE
- rd_req  in  1  MFHI/MFLO in EX
- rd_sel  in  1  1 = Hi, 0 = Lo
- rd_data  out  32  combinational read of the selected register
- stall  out  1  rd_req && busy (combinational)
- div_zero  out  1  one-cycle pulse on commit of divide by zero
- hi_out, lo_out  out  32  current Hi / Lo register contents

## Operation
- States: IDLE, MUL, DIV, FIX (only with HILO_SIGNED_EN), DONE.
- IDLE: on accept of MTHI/MTLO, write src_a into Hi/Lo at that edge; stay IDLE. On MULTU/DIVU: latch operands, clear 6-bit counter, go to MUL/DIV. Illegal codes are accepted and dropped, no state change.
- MUL: per cycle, if multiplier LSB add multiplicand into upper half of 64-bit accumulator (33-bit carry), shift right 1. DIV: restoring; shift {rem,quot} left 1, subtract divisor from 33-bit remainder, keep if non-negative and set quotient bit.
- Counter increments each MUL/DIV cycle; at count 31 go to DONE (FIX for signed ops).
- DONE: write Hi = product[63:32] / remainder, Lo = product[31:0] / quotient; go IDLE.
- Divisor 0: IDLE goes directly to DONE; commit Hi = src_a, Lo = 32'hFFFF_FFFF; div_zero high during the DONE cycle.
- rd_data reflects registered Hi/Lo only; no bypass of an in-flight result or same-cycle MT write (reader sees old value).
- op_valid while busy is not accepted; requester holds op_valid/op_code/operands stable until accepted.
- Reset (any state, any time): state IDLE, counter 0, Hi = Lo = 0, all outputs 0 except op_ready = 1. Operation in flight is discarded.

## Timing
- MT*: visible on hi_out/lo_out at the accepting edge (latency 1).
- MULTU/DIVU: accept edge E; MUL/DIV occupy edges E+1..E+32; DONE commits at E+33; op_ready high again after E+33.
- Divide by zero: commit at E+1.
- Signed ops add one FIX cycle: commit at E+34.
- stall asserts the same cycle rd_req is high with busy set, deasserts in the cycle after commit.
- Back-to-back: a new op can be accepted in the first IDLE cycle following DONE.

## Configuration
- HILO_SIGNED_EN defined: MULT/DIV accepted; operands converted to magnitudes at accept, signs latched; FIX state negates product (sign a ^ sign b), quotient (sign a ^ sign b) and remainder (sign a) before DONE. Divide by zero identical to unsigned.
- Not defined: FIX state and sign logic absent; codes 100/101 treated as illegal (accepted, dropped).

## Test plan
- Reset released, MTHI 0x1234_5678 then MTLO 0xDEAD_BEEF -> hi_out 0x12345678, lo_out 0xDEADBEEF, each one edge after accept; op_ready stays 1.
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF -> at E+33 hi = 0xFFFF_FFFE, lo = 0x0000_0001; busy high E+1..E+33.
- DIVU 100 / 7 -> hi = 2, lo = 14 at E+33; MFHI (rd_req=1, rd_sel=1) issued at E+5 -> stall high until commit, then rd_data = 2.
- DIVU 0x55 / 0 -> at E+1 hi = 0x55, lo = 0xFFFF_FFFF, div_zero pulse one cycle.
- MULTU 3×5 accepted, reset asserted at E+10 -> immediately hi = lo = 0, busy 0, op_ready 1; no later commit.
- With HILO_SIGNED_EN: DIV -7 / 2 -> at E+34 lo = 0xFFFF_FFFD, hi = 0xFFFF_FFFF; MULT -3 × 4 -> hi = 0xFFFF_FFFF, lo = 0xFFFF_FFF4.
